// File: rtl/ones_pkg.sv
// Shared types and defaults for the ones pattern generator and its index counter.
package ones_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int N_DEF  = 7;
  localparam int CW_DEF = 3;

  // Index width for an N-position counter; never narrower than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int IW_DEF = idx_width(N_DEF);

endpackage

// File: rtl/ones_pattern_gen_if.sv
// Request/serial/parallel signal bundle between a pattern requester and ones_pattern_gen.
interface ones_pattern_gen_if #(
  parameter int N  = 7,
  parameter int CW = 3
);

  logic          start;
  logic [CW-1:0] count;
  logic          busy;
  logic          bit_valid;
  logic          bit_out;
  logic          done;
  logic [N-1:0]  word;
  logic [CW-1:0] ones_seen;

  modport master (
    output start,
    output count,
    input  busy,
    input  bit_valid,
    input  bit_out,
    input  done,
    input  word,
    input  ones_seen
  );

  modport slave (
    input  start,
    input  count,
    output busy,
    output bit_valid,
    output bit_out,
    output done,
    output word,
    output ones_seen
  );

endinterface

// File: rtl/ones_bit_index.sv
// Bit-position counter for the serial pattern: clear, enable, wrap at N-1 with terminal flag.
module ones_bit_index
  import ones_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int IW = IW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          en,
  output logic [IW-1:0] idx,
  output logic [IW-1:0] idx_nxt,
  output logic          tc
);

  logic [IW-1:0] idx_q;
  logic [IW-1:0] idx_d;

  assign tc = (idx_q == IW'(N - 1));

  always_comb begin
    idx_d = idx_q;
    if (clr) begin
      idx_d = '0;
    end else if (en) begin
      idx_d = tc ? '0 : idx_q + IW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else begin
      idx_q <= idx_d;
    end
  end

  assign idx     = idx_q;
  assign idx_nxt = idx_d;

endmodule

// File: rtl/ones_pattern_gen.sv
// Emits an N-bit thermometer word (LSB first) holding the requested number of ones,
// then presents the assembled word with a one-cycle done pulse.
module ones_pattern_gen
  import ones_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int CW = CW_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  ones_pattern_gen_if.slave bus
);

  localparam int IW = idx_width(N);

  state_e        state_q, state_d;
  logic [CW-1:0] k_q, k_d;
  logic [CW-1:0] ones_seen_q, ones_seen_d;
  logic [N-1:0]  shift_q, shift_d;
  logic [N-1:0]  word_q, word_d;
  logic          busy_q, busy_d;
  logic          bit_valid_q, bit_valid_d;
  logic          bit_out_q, bit_out_d;
  logic          done_q, done_d;

  logic          idx_clr;
  logic          idx_en;
  logic          idx_tc;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_nxt;

  assign idx_clr = (state_q == IDLE) && bus.start;
  assign idx_en  = (state_q == SHIFT);

  ones_bit_index #(
    .N  (N),
    .IW (IW)
  ) u_index (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (idx_clr),
    .en      (idx_en),
    .idx     (idx),
    .idx_nxt (idx_nxt),
    .tc      (idx_tc)
  );

  // Outputs are computed from next-state values so every port comes straight from a flop.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    ones_seen_d = ones_seen_q;
    shift_d     = shift_q;
    word_d      = word_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d     = SHIFT;
          k_d         = (int'(bus.count) > N) ? CW'(N) : bus.count;
          ones_seen_d = '0;
          shift_d     = '0;
        end
      end
      SHIFT: begin
        shift_d[idx] = bit_out_q;
        ones_seen_d  = ones_seen_q + CW'(bit_out_q);
        if (idx_tc) begin
          state_d = DONE;
          word_d  = shift_d;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d      = (state_d != IDLE);
    bit_valid_d = (state_d == SHIFT);
    bit_out_d   = bit_valid_d && (int'(idx_nxt) < int'(k_d));
    done_d      = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      ones_seen_q <= '0;
      shift_q     <= '0;
      word_q      <= '0;
      busy_q      <= 1'b0;
      bit_valid_q <= 1'b0;
      bit_out_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      ones_seen_q <= ones_seen_d;
      shift_q     <= shift_d;
      word_q      <= word_d;
      busy_q      <= busy_d;
      bit_valid_q <= bit_valid_d;
      bit_out_q   <= bit_out_d;
      done_q      <= done_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.bit_valid = bit_valid_q;
  assign bus.bit_out   = bit_out_q;
  assign bus.done      = done_q;
  assign bus.word      = word_q;
  assign bus.ones_seen = ones_seen_q;

endmodule

// File: tb/tb_ones_pattern_gen.sv
// Directed bench for ones_pattern_gen: N=7 instance for the main sequences, N=5 instance for clamping.
module tb_ones_pattern_gen;

  logic clk = 1'b0;
  logic rst_n;
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  int   lastDoneAt = 0;

  ones_pattern_gen_if #(.N(7), .CW(3)) bus7 ();
  ones_pattern_gen_if #(.N(5), .CW(3)) bus5 ();

  ones_pattern_gen #(.N(7), .CW(3)) dut7 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus7)
  );

  ones_pattern_gen #(.N(5), .CW(3)) dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus5)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference for the downstream 7-input ones counter.
  function automatic int onesCounter7(input logic [6:0] w);
    int n = 0;
    for (int b = 0; b < 7; b++) n += int'(w[b]);
    return n;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic [2:0] c);
    bus7.start = s;
    bus7.count = c;
  endtask

  // One full N=7 transaction starting in the current IDLE cycle; returns in the first IDLE cycle after done.
  task automatic runWord7(input int cnt, input logic holdStart);
    logic [6:0] expWord;
    expWord = 7'((1 << cnt) - 1);
    applyStimulus(1'b1, 3'(cnt));
    tick();
    if (!holdStart) applyStimulus(1'b0, 3'd0);
    for (int b = 0; b < 7; b++) begin
      checkOutput($sformatf("valid7_c%0d_b%0d", cnt, b), bus7.bit_valid, 1);
      checkOutput($sformatf("bit7_c%0d_b%0d", cnt, b), bus7.bit_out, (b < cnt) ? 1 : 0);
      checkOutput($sformatf("early_done7_c%0d_b%0d", cnt, b), bus7.done, 0);
      if (holdStart) bus7.count = bus7.count ^ 3'b111;
      tick();
    end
    lastDoneAt = cyc;
    checkOutput($sformatf("done7_c%0d", cnt), bus7.done, 1);
    checkOutput($sformatf("busy_at_done7_c%0d", cnt), bus7.busy, 1);
    checkOutput($sformatf("valid_at_done7_c%0d", cnt), bus7.bit_valid, 0);
    checkOutput($sformatf("word7_c%0d", cnt), bus7.word, expWord);
    checkOutput($sformatf("ones_seen7_c%0d", cnt), bus7.ones_seen, cnt);
    checkOutput($sformatf("counter_roundtrip_c%0d", cnt), onesCounter7(bus7.word), cnt);
    applyStimulus(1'b0, 3'd0);
    tick();
    checkOutput($sformatf("done_pulse7_c%0d", cnt), bus7.done, 0);
    checkOutput($sformatf("idle_busy7_c%0d", cnt), bus7.busy, 0);
    checkOutput($sformatf("word_held7_c%0d", cnt), bus7.word, expWord);
    checkOutput($sformatf("ones_held7_c%0d", cnt), bus7.ones_seen, cnt);
  endtask

  initial begin
    int firstDone;
    int dones;

    // Reset state
    rst_n      = 1'b0;
    applyStimulus(1'b0, 3'd0);
    bus5.start = 1'b0;
    bus5.count = 3'd0;
    #3;
    checkOutput("rst_busy7", bus7.busy, 0);
    checkOutput("rst_valid7", bus7.bit_valid, 0);
    checkOutput("rst_bit7", bus7.bit_out, 0);
    checkOutput("rst_done7", bus7.done, 0);
    checkOutput("rst_word7", bus7.word, 0);
    checkOutput("rst_ones7", bus7.ones_seen, 0);
    checkOutput("rst_word5", bus5.word, 0);
    checkOutput("rst_busy5", bus5.busy, 0);
    tick(2);
    rst_n = 1'b1;
    tick();

    $display("[TB] count=3 single transaction");
    runWord7(3, 1'b0);

    $display("[TB] count=0 then count=7 back-to-back");
    runWord7(0, 1'b0);
    firstDone = lastDoneAt;
    runWord7(7, 1'b0);
    checkOutput("done_spacing", lastDoneAt - firstDone, 9);

    $display("[TB] start held and count toggled while busy");
    runWord7(5, 1'b1);
    tick();
    checkOutput("no_queued_start_busy", bus7.busy, 0);
    checkOutput("no_queued_start_word", bus7.word, 7'b0011111);

    $display("[TB] asynchronous reset mid-transaction");
    applyStimulus(1'b1, 3'd6);
    tick();
    applyStimulus(1'b0, 3'd0);
    tick(3);
    checkOutput("pre_reset_valid", bus7.bit_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_busy", bus7.busy, 0);
    checkOutput("async_valid", bus7.bit_valid, 0);
    checkOutput("async_bit", bus7.bit_out, 0);
    checkOutput("async_done", bus7.done, 0);
    checkOutput("async_word", bus7.word, 0);
    checkOutput("async_ones", bus7.ones_seen, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 10; c++) begin
      if (bus7.done === 1'b1) dones++;
      tick();
    end
    checkOutput("no_done_after_reset", dones, 0);
    runWord7(2, 1'b0);

    $display("[TB] sweep count 0..7");
    for (int c = 0; c < 8; c++) runWord7(c, 1'b0);

    $display("[TB] N=5 clamp with count=7");
    bus5.start = 1'b1;
    bus5.count = 3'd7;
    tick();
    bus5.start = 1'b0;
    for (int b = 0; b < 5; b++) begin
      checkOutput($sformatf("valid5_b%0d", b), bus5.bit_valid, 1);
      checkOutput($sformatf("bit5_b%0d", b), bus5.bit_out, 1);
      checkOutput($sformatf("early_done5_b%0d", b), bus5.done, 0);
      tick();
    end
    checkOutput("done5", bus5.done, 1);
    checkOutput("word5", bus5.word, 5'b11111);
    checkOutput("ones_seen5", bus5.ones_seen, 5);
    tick();
    checkOutput("done5_pulse", bus5.done, 0);
    checkOutput("idle_busy5", bus5.busy, 0);
    checkOutput("word5_held", bus5.word, 5'b11111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
